alu_pipelined_param: RTL and testbench
======================================

# alu_pipelined_param

Parametrised, three-stage pipelined ALU with valid/ready flow control, tag pass-through and optional saturating arithmetic. It is the next-generation datapath ALU: same operation set and flag outputs as the fixed 8-bit pipelined ALU, generalised to WIDTH bits. It adds backpressure, arithmetic right shift and saturation modes. It sits between an operand-issue stage (upstream, valid/ready) and a result-writeback stage (downstream, valid/ready).

## Interface
- WIDTH, 8, operand/result width; power of two, >= 4
- TAG_W, 4, width of opaque tag carried alongside each operation
- SH_W, $clog2(WIDTH), derived local parameter; shift-amount width, not overridable
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; for shifts, B[SH_W-1:0] is the shift amount and upper bits are ignored
- opcode  in  3  operation select
- signed_op  in  1  signed interpretation (overflow, saturation bounds, SHR kind)
- sat_op  in  1  saturate ADD/SUB results
- tag_in  in  TAG_W  tag, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  final result
- carry, overflow, zero, negative  out  1 each  flags for result
- tag_out  out  TAG_W  tag of this result

## Operation
- Opcodes:
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL A by sh
  - 111 SHR A by sh; logical when signed_op=0, arithmetic (sign-fill) when signed_op=1
- carry:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: borrow, i.e. 1 iff A<B unsigned.
  - SHL/SHR: last bit shifted out; 0 when sh=0.
  - Logic ops: 0.
- overflow: 1 only for ADD/SUB with signed_op=1 and two's-complement overflow; else 0.
- Saturation applies only when sat_op=1 and opcode is ADD/SUB; sat_op is ignored for other opcodes.
  - Unsigned (signed_op=0): ADD with carry clamps to all-ones; SUB with borrow clamps to 0.
  - Signed (signed_op=1): on overflow, clamps to 0111…1 if the true result is positive, else 1000…0.
  - carry/overflow report the pre-saturation condition.
- zero = (result == 0) and negative = result[WIDTH-1]. Both are computed on the final (post-saturation) result.
- Pipeline stages:
  - S1: register operands, opcode, modes and tag.
  - S2: raw result, carry, overflow.
  - S3: saturation, zero/negative; drives the outputs.
- Each stage has its own valid bit. Invalid stages carry don't-care data, but output data is held at the last valid values.

## Timing
- Reset (rst_n low at a rising edge): all stage valids and out_valid = 0; result, flags and tag_out = 0; in_ready = 0 while rst_n is low.
- Global enable: en = !out_valid || out_ready. in_ready = en && rst_n. There is no bubble squeezing; a stall freezes all stages.
- Transfer in: in_valid && in_ready at edge k. Result then appears with out_valid=1 after edge k+3 when no stall occurs. Latency is 3 cycles, throughput 1 op/cycle.
- Transfer out: out_valid && out_ready at an edge.
- While out_valid && !out_ready: all stage registers, outputs and tag hold. in_ready = 0, and input data is ignored.
- Simultaneous: a downstream accept and an upstream accept in the same edge are both legal; the pipeline advances by one.
- Bubbles: a cycle with in_valid=0 and en=1 inserts an invalid slot that propagates; out_valid=0 three cycles later.
- Reset mid-operation: all in-flight operations are discarded with no output. The first accept after release produces a result 3 cycles later.
- Input signals need not be stable when in_valid=0 or in_ready=0.

## Test plan
- WIDTH=8. A=10, B=20, ADD, unsigned, single op -> result 30, carry=0, overflow=0, zero=0, negative=0; out_valid exactly 3 cycles after accept; tag_out = tag_in.
- A=127, B=1: ADD signed, sat_op=0 -> result 0x80, overflow=1, negative=1. Same operands with sat_op=1 -> result 0x7F, overflow=1, negative=0.
- Saturating cases:
  - A=0, B=1, SUB, unsigned, sat_op=1 -> result 0x00, carry=1, zero=1.
  - A=200, B=100, ADD, unsigned, sat_op=1 -> result 0xFF, carry=1.
- Shifts: A=0x96, B=3.
  - SHR unsigned -> 0x12, carry=1.
  - SHR signed -> 0xF2, carry=1.
  - SHL -> 0xB0, carry=0.
  - B=0x0B (upper bits ignored, sh=3) -> results identical to B=3.
- Backpressure: stream tags 1..6 back-to-back and hold out_ready=0 for 4 cycles after the first result. Required: in_ready=0 during the hold, outputs frozen, no loss or duplication; tags exit in order 1..6.
- Reset mid-stream: 3 ops in flight, assert rst_n=0 for 1 cycle -> outputs and flags 0, none of the 3 results appear. A new op accepted after release emerges 3 cycles later.

Source files
------------

// File: rtl/alu_pipelined_param.sv
// WIDTH-bit ALU (add/sub/logic/shift, optional saturation) with an opaque tag carried alongside each op.
// Latency: out_valid rises 3 edges after the accept edge; throughput one op per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready; no bubble squeezing.
module alu_pipelined_param #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             signed_op,
    input  logic             sat_op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [TAG_W-1:0] tag_out
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // One enable for the whole pipe: a stalled output freezes everything behind it.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en && rst_n;

    // S1 registers
    logic             v1;
    logic [WIDTH-1:0] a1, b1;
    logic [2:0]       op1;
    logic             sgn1, sat1;
    logic [TAG_W-1:0] tag1;

    // S2 registers: raw result and pre-saturation flags
    logic             v2;
    logic [WIDTH-1:0] r2;
    logic             c2, ov2, sgn2, sat2, sub2;
    logic [TAG_W-1:0] tag2;

    // S3 registers: saturated result; zero/negative are evaluated into the output registers
    logic             v3;
    logic [WIDTH-1:0] r3;
    logic             c3, ov3;
    logic [TAG_W-1:0] tag3;

    // S1: capture the accepted operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            op1  <= '0;
            sgn1 <= 1'b0;
            sat1 <= 1'b0;
            tag1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1   <= A;
                b1   <= B;
                op1  <= opcode;
                sgn1 <= signed_op;
                sat1 <= sat_op;
                tag1 <= tag_in;
            end
        end
    end

    // Raw result: operate on WIDTH+1 bits so the extra bit yields carry/borrow/shifted-out bit.
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] raw;
    logic             raw_c, raw_ov;
    assign sh = b1[SH_W-1:0];

    // S2 combinational datapath
    always_comb begin
        ext    = '0;
        raw    = '0;
        raw_c  = 1'b0;
        raw_ov = 1'b0;
        case (op1)
            OP_ADD: begin
                ext    = {1'b0, a1} + {1'b0, b1};
                raw    = ext[MSB:0];
                raw_c  = ext[WIDTH];
                raw_ov = sgn1 && (a1[MSB] == b1[MSB]) && (raw[MSB] != a1[MSB]);
            end
            OP_SUB: begin
                ext    = {1'b0, a1} - {1'b0, b1};
                raw    = ext[MSB:0];
                raw_c  = ext[WIDTH];
                raw_ov = sgn1 && (a1[MSB] != b1[MSB]) && (raw[MSB] != a1[MSB]);
            end
            OP_AND: raw = a1 & b1;
            OP_OR:  raw = a1 | b1;
            OP_XOR: raw = a1 ^ b1;
            OP_NOT: raw = ~a1;
            OP_SHL: begin
                ext   = {1'b0, a1} << sh;
                raw   = ext[MSB:0];
                raw_c = ext[WIDTH];
            end
            OP_SHR: begin
                // A guard bit below the LSB catches the last bit shifted out.
                if (sgn1) ext = $unsigned($signed({a1, 1'b0}) >>> sh);
                else      ext = {a1, 1'b0} >> sh;
                raw   = ext[WIDTH:1];
                raw_c = ext[0];
            end
            default: raw = '0;
        endcase
    end

    // S2: register raw result and what saturation needs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            r2   <= '0;
            c2   <= 1'b0;
            ov2  <= 1'b0;
            sgn2 <= 1'b0;
            sat2 <= 1'b0;
            sub2 <= 1'b0;
            tag2 <= '0;
        end else if (en) begin
            v2   <= v1;
            r2   <= raw;
            c2   <= raw_c;
            ov2  <= raw_ov;
            sgn2 <= sgn1;
            sat2 <= sat1 && ((op1 == OP_ADD) || (op1 == OP_SUB));
            sub2 <= (op1 == OP_SUB);
            tag2 <= tag1;
        end
    end

    // Saturation: on signed overflow the raw sign is the inverse of the true sign.
    logic [WIDTH-1:0] sat_res;
    always_comb begin
        sat_res = r2;
        if (sat2) begin
            if (sgn2) begin
                if (ov2) sat_res = r2[MSB] ? {1'b0, {MSB{1'b1}}} : {1'b1, {MSB{1'b0}}};
            end else if (c2) begin
                sat_res = sub2 ? '0 : '1;
            end
        end
    end

    // S3: register saturated result; carry/overflow keep the pre-saturation condition
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3   <= 1'b0;
            r3   <= '0;
            c3   <= 1'b0;
            ov3  <= 1'b0;
            tag3 <= '0;
        end else if (en) begin
            v3   <= v2;
            r3   <= sat_res;
            c3   <= c2;
            ov3  <= ov2;
            tag3 <= tag2;
        end
    end

    // Output registers: update only on a valid slot so outputs hold the last valid result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            tag_out   <= '0;
        end else if (en) begin
            out_valid <= v3;
            if (v3) begin
                result   <= r3;
                carry    <= c3;
                overflow <= ov3;
                zero     <= (r3 == '0);
                negative <= r3[MSB];
                tag_out  <= tag3;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipelined_param.sv
// Bench for alu_pipelined_param at WIDTH=8: directed ops, random batches, backpressure and mid-stream reset.
// Expected results come from an integer reference model pushed on accept, popped on output transfer.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_alu_pipelined_param;
    localparam int W  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A, B;
    logic [2:0]    opcode;
    logic          signed_op, sat_op;
    logic [TW-1:0] tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry, overflow, zero, negative;
    logic [TW-1:0] tag_out;

    alu_pipelined_param #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .signed_op(signed_op), .sat_op(sat_op),
        .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .negative(negative), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic          c, ov, z, n;
        logic [TW-1:0] tag;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   pops  = 0;
    bit   lat_chk = 1'b1;
    logic [W-1:0] last_res;
    logic         last_c, last_ov, last_z, last_n;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                   input logic sgn, input logic sat, input logic [3:0] tag);
        int ua, ub, sa, sb, full, tr, sh;
        exp_t r;
        ua = a; ub = b;
        sa = a[7] ? ua - 256 : ua;
        sb = b[7] ? ub - 256 : ub;
        sh = ub % 8;
        tr = 0; full = 0;
        r.c = 1'b0; r.ov = 1'b0;
        case (op)
            3'd0: begin full = ua + ub; r.c = (full > 255); tr = sa + sb;
                        r.ov = sgn && (tr > 127 || tr < -128); end
            3'd1: begin full = ua - ub; r.c = (ua < ub); tr = sa - sb;
                        r.ov = sgn && (tr > 127 || tr < -128); end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: full = 255 - ua;
            3'd6: begin full = ua << sh; r.c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1); end
            default: begin full = sgn ? (sa >>> sh) : (ua >> sh);
                           r.c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
        endcase
        r.res = 8'(full & 255);
        if (sat && op < 3'd2) begin
            if (sgn) begin
                if (r.ov) r.res = (tr > 0) ? 8'h7F : 8'h80;
            end else if (r.c) begin
                r.res = (op == 3'd0) ? 8'hFF : 8'h00;
            end
        end
        r.z = (r.res == 8'h00);
        r.n = r.res[7];
        r.tag = tag;
        r.acc = 0;
        r.lat = 1'b0;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accept, pop and compare on output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_output observed tag=%0d result=0x%0h expected none", tag_out, result);
                end else begin
                    e = q.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("carry", 32'(carry), 32'(e.c));
                    chk("overflow", 32'(overflow), 32'(e.ov));
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("negative", 32'(negative), 32'(e.n));
                    chk("tag_out", 32'(tag_out), 32'(e.tag));
                    if (e.lat) chk("latency", 32'(cyc), 32'(e.acc + 3));
                    last_res = result; last_c = carry; last_ov = overflow;
                    last_z = zero; last_n = negative;
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                e = model(A, B, opcode, signed_op, sat_op, tag_in);
                e.acc = cyc + 1;
                e.lat = lat_chk;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic sgn, input logic sat, input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; A = a; B = b; opcode = op; signed_op = sgn; sat_op = sat; tag_in = tag;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        A = 8'hA5; B = 8'h5A;
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic sgn, input logic sat, input logic [3:0] tag,
                        input logic [7:0] xr, input logic xc, input logic xov,
                        input logic xz, input logic xn);
        send(a, b, op, sgn, sat, tag);
        drain();
        chk("const_result", 32'(last_res), 32'(xr));
        chk("const_carry", 32'(last_c), 32'(xc));
        chk("const_overflow", 32'(last_ov), 32'(xov));
        chk("const_zero", 32'(last_z), 32'(xz));
        chk("const_negative", 32'(last_n), 32'(xn));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; opcode = '0; signed_op = 1'b0; sat_op = 1'b0; tag_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({carry, overflow, zero, negative}), 32'd0);
        chk("rst_tag", 32'(tag_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed single ops (A, B, op, signed, sat, tag -> result, c, ov, z, n)
        run1(8'd10,  8'd20,  3'd0, 1'b0, 1'b0, 4'd5, 8'd30,  1'b0, 1'b0, 1'b0, 1'b0);
        run1(8'd127, 8'd1,   3'd0, 1'b1, 1'b0, 4'd1, 8'h80,  1'b0, 1'b1, 1'b0, 1'b1);
        run1(8'd127, 8'd1,   3'd0, 1'b1, 1'b1, 4'd2, 8'h7F,  1'b0, 1'b1, 1'b0, 1'b0);
        run1(8'd0,   8'd1,   3'd1, 1'b0, 1'b1, 4'd3, 8'h00,  1'b1, 1'b0, 1'b1, 1'b0);
        run1(8'd200, 8'd100, 3'd0, 1'b0, 1'b1, 4'd4, 8'hFF,  1'b1, 1'b0, 1'b0, 1'b1);
        run1(8'h96,  8'd3,   3'd7, 1'b0, 1'b0, 4'd6, 8'h12,  1'b1, 1'b0, 1'b0, 1'b0);
        run1(8'h96,  8'd3,   3'd7, 1'b1, 1'b0, 4'd7, 8'hF2,  1'b1, 1'b0, 1'b0, 1'b1);
        run1(8'h96,  8'd3,   3'd6, 1'b0, 1'b0, 4'd8, 8'hB0,  1'b0, 1'b0, 1'b0, 1'b1);
        run1(8'h96,  8'h0B,  3'd7, 1'b0, 1'b0, 4'd9, 8'h12,  1'b1, 1'b0, 1'b0, 1'b0);
        run1(8'h96,  8'h0B,  3'd7, 1'b1, 1'b0, 4'd10, 8'hF2, 1'b1, 1'b0, 1'b0, 1'b1);
        run1(8'h96,  8'h0B,  3'd6, 1'b0, 1'b0, 4'd11, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1);
        run1(8'h80,  8'd1,   3'd1, 1'b1, 1'b1, 4'd12, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        run1(8'hF0,  8'h3C,  3'd2, 1'b0, 1'b1, 4'd13, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run1(8'h55,  8'h00,  3'd5, 1'b0, 1'b0, 4'd14, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        run1(8'h81,  8'd0,   3'd6, 1'b0, 1'b0, 4'd15, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random back-to-back stream, no stalls: latency checked on every op
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        drain();

        // Random stream against random downstream stalls
        lat_chk = 1'b0;
        fork
            for (int i = 0; i < 12; i++)
                send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        join
        out_ready = 1'b1;
        drain();

        // Backpressure: tags 1..6 back-to-back, out_ready low for 4 cycles after first result
        p0 = pops;
        fork
            for (int t = 1; t <= 6; t++) send(8'(t * 10), 8'(t), 3'd0, 1'b0, 1'b0, 4'(t));
            begin
                for (int i = 0; i < 20 && !out_valid; i++) begin
                    @(posedge clk); #1;
                end
                chk("bp_first_result", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_tag_held", 32'(tag_out), 32'd1);
                    chk("bp_result_held", 32'(result), 32'd11);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(pops - p0), 32'd6);
        lat_chk = 1'b1;

        // Reset mid-stream: three ops in flight are discarded
        send(8'd1, 8'd2, 3'd0, 1'b0, 1'b0, 4'd7);
        send(8'd3, 8'd4, 3'd0, 1'b0, 1'b0, 4'd8);
        send(8'd5, 8'd6, 3'd0, 1'b0, 1'b0, 4'd9);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_flags", 32'({carry, overflow, zero, negative}), 32'd0);
        chk("mid_rst_tag", 32'(tag_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_ghost", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        run1(8'd50, 8'd8, 3'd1, 1'b0, 1'b0, 4'd10, 8'd42, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
